// File: rtl/piso_serializer_nbit_pkg.sv
// Shared definitions for the PISO serializer: FSM state encoding and counter sizing.
// Used by the top level, the bit counter and the handshake interface users.
package piso_serializer_nbit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Counter must hold 0..n-1; a 1-bit word still needs one counter bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_serializer_nbit_if.sv
// Load handshake and serial output bundle of the PISO serializer.
// master = upstream/observer side, slave = serializer side.
interface piso_serializer_nbit_if #(
  parameter int N = 4
);
  logic [N-1:0] I;
  logic         load_valid;
  logic         load_ready;
  logic         sout;
  logic         sout_valid;
  logic         busy;
  logic         done;

  modport master (
    output I, load_valid,
    input  load_ready, sout, sout_valid, busy, done
  );

  modport slave (
    input  I, load_valid,
    output load_ready, sout, sout_valid, busy, done
  );
endinterface

// File: rtl/piso_serializer_nbit_bit_counter_mod.sv
// Modulo-MOD up-counter with sync clear and enable; tc flags the terminal value MOD-1.
// The count is internal: the serializer only needs the final-bit indication.
module bit_counter_mod
  import piso_serializer_nbit_pkg::*;
#(
  parameter int MOD = 4,
  parameter int W   = cnt_width(MOD)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] count;

  assign tc = (count == LAST);

  // Clear wins over enable so a word accepted on the final bit restarts at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/piso_serializer_nbit.sv
// N-bit parallel-in/serial-out serializer with valid/ready load and back-to-back frames.
// Optional trailing even-parity bit when PISO_SERIALIZER_PARITY_BIT_EN is defined.
module piso_serializer_nbit
  import piso_serializer_nbit_pkg::*;
#(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  piso_serializer_nbit_if.slave bus
);

  state_t       state;
  state_t       state_next;
  logic [N-1:0] shift_reg;
  logic         accept;
  logic         last_bit;
  logic         cnt_en;
`ifdef PISO_SERIALIZER_PARITY_BIT_EN
  logic         parity_bit;
`endif

  assign accept = bus.load_valid && bus.load_ready;
  assign cnt_en = (state == SHIFT);

  bit_counter_mod #(
    .MOD(N)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (cnt_en),
    .tc    (last_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Shift toward the output end; vacated bits fill with zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= '0;
    end else if (accept) begin
      shift_reg <= bus.I;
    end else if (state == SHIFT) begin
      shift_reg <= MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);
    end
  end

`ifdef PISO_SERIALIZER_PARITY_BIT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_bit <= 1'b0;
    end else if (accept) begin
      parity_bit <= ^bus.I;
    end
  end
`endif

  // In the final cycle load_ready is 1, so load_valid alone decides a restart.
  always_comb begin
    state_next     = state;
    bus.load_ready = 1'b0;
    bus.sout       = 1'b0;
    bus.sout_valid = 1'b0;
    bus.done       = 1'b0;
    bus.busy       = 1'b0;
    case (state)
      IDLE: begin
        bus.load_ready = 1'b1;
        if (bus.load_valid) state_next = SHIFT;
      end
      SHIFT: begin
        bus.sout_valid = 1'b1;
        bus.busy       = 1'b1;
        bus.sout       = MSB_FIRST ? shift_reg[N-1] : shift_reg[0];
        if (last_bit) begin
`ifdef PISO_SERIALIZER_PARITY_BIT_EN
          state_next = PARITY;
`else
          bus.load_ready = 1'b1;
          bus.done       = 1'b1;
          state_next     = bus.load_valid ? SHIFT : IDLE;
`endif
        end
      end
`ifdef PISO_SERIALIZER_PARITY_BIT_EN
      PARITY: begin
        bus.sout_valid = 1'b1;
        bus.busy       = 1'b1;
        bus.sout       = parity_bit;
        bus.load_ready = 1'b1;
        bus.done       = 1'b1;
        state_next     = bus.load_valid ? SHIFT : IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_serializer_nbit.sv
// Bench for piso_serializer_nbit: MSB-first, LSB-first (N=4) and N=1 instances against a frame-queue model.
// Honours PISO_SERIALIZER_PARITY_BIT_EN for the expected frame contents.
module tb_piso_serializer_nbit;

  logic       clk;
  logic       reset;
  logic       lv;
  logic [3:0] din;

  int errors = 0;
  int checks = 0;

  piso_serializer_nbit_if #(.N(4)) if_msb ();
  piso_serializer_nbit_if #(.N(4)) if_lsb ();
  piso_serializer_nbit_if #(.N(1)) if_n1 ();

  assign if_msb.I = din;
  assign if_lsb.I = din;
  assign if_n1.I  = din[0];
  assign if_msb.load_valid = lv;
  assign if_lsb.load_valid = lv;
  assign if_n1.load_valid  = lv;

  piso_serializer_nbit #(.N(4), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .reset(reset), .bus(if_msb));
  piso_serializer_nbit #(.N(4), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .reset(reset), .bus(if_lsb));
  piso_serializer_nbit #(.N(1), .MSB_FIRST(1'b1)) u_n1  (.clk(clk), .reset(reset), .bus(if_n1));

  logic so[3], sv[3], lr[3], dn[3], bs[3];
  assign so[0] = if_msb.sout; assign sv[0] = if_msb.sout_valid; assign lr[0] = if_msb.load_ready;
  assign dn[0] = if_msb.done; assign bs[0] = if_msb.busy;
  assign so[1] = if_lsb.sout; assign sv[1] = if_lsb.sout_valid; assign lr[1] = if_lsb.load_ready;
  assign dn[1] = if_lsb.done; assign bs[1] = if_lsb.busy;
  assign so[2] = if_n1.sout;  assign sv[2] = if_n1.sout_valid;  assign lr[2] = if_n1.load_ready;
  assign dn[2] = if_n1.done;  assign bs[2] = if_n1.busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each instance holds the bits still to be sent; the head is the current bit.
  bit q[3][$];
  int nw[3]   = '{4, 4, 1};
  bit msbf[3] = '{1'b1, 1'b0, 1'b1};
  bit acc0;
  bit rec;
  bit stream[$];

  function automatic void load_frame(int i, logic [3:0] w);
    bit par = 1'b0;
    q[i].delete();
    for (int k = 0; k < nw[i]; k++) begin
      int idx = msbf[i] ? (nw[i] - 1 - k) : k;
      q[i].push_back(w[idx]);
      par ^= w[k];
    end
`ifdef PISO_SERIALIZER_PARITY_BIT_EN
    q[i].push_back(par);
`endif
  endfunction

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkv(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle(input bit chk);
    bit rdy[3];
    #1;
    for (int i = 0; i < 3; i++) begin
      int n = q[i].size();
      logic es = (n > 0) ? q[i][0] : 1'b0;
      rdy[i] = (n <= 1);
      if (chk) begin
        check1($sformatf("sout%0d", i),       so[i], es);
        check1($sformatf("sout_valid%0d", i), sv[i], n > 0);
        check1($sformatf("load_ready%0d", i), lr[i], n <= 1);
        check1($sformatf("done%0d", i),       dn[i], n == 1);
        check1($sformatf("busy%0d", i),       bs[i], n > 0);
      end
    end
    if (rec && sv[0]) stream.push_back(so[0]);
    @(posedge clk);
    acc0 = !reset && lv && rdy[0];
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        q[i].delete();
      end else begin
        if (q[i].size() > 0) void'(q[i].pop_front());
        if (lv && rdy[i]) load_frame(i, din);
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [3:0] w);
    bit ok = 1'b0;
    din = w;
    lv  = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      cycle(1'b1);
      ok = acc0;
    end
    lv = 1'b0;
    check1("send_accept", ok, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b1);
  endtask

  initial begin
    logic [15:0] got;
    logic [15:0] exp_stream;
    int          exp_len;
    reset = 1'b1;
    lv    = 1'b1;
    din   = 4'hF;
    rec   = 1'b0;
    @(negedge clk);
    cycle(1'b0);
    cycle(1'b1);
    reset = 1'b0;
    lv    = 1'b0;
    idle(2);

    send(4'hB);
    idle(6);

    rec = 1'b1;
    send(4'hB);
    send(4'h4);
    for (int k = 0; k < 12 && q[0].size() > 0; k++) cycle(1'b1);
    rec = 1'b0;
    got = '0;
    foreach (stream[k]) got = {got[14:0], stream[k]};
`ifdef PISO_SERIALIZER_PARITY_BIT_EN
    exp_stream = 16'b1011101001;
    exp_len    = 10;
`else
    exp_stream = 16'b10110100;
    exp_len    = 8;
`endif
    checkv("b2b_len", 16'(stream.size()), 16'(exp_len));
    checkv("b2b_bits", got, exp_stream);
    idle(2);

    send(4'h6);
    send(4'hF);
    idle(7);

    send(4'hA);
    cycle(1'b1);
    reset = 1'b1;
    cycle(1'b1);
    reset = 1'b0;
    idle(1);
    send(4'h1);
    idle(6);

    send(4'h7);
    send(4'h3);
    idle(7);

    for (int k = 0; k < 400; k++) begin
      lv    = 1'($urandom_range(0, 1));
      din   = 4'($urandom);
      reset = ($urandom_range(0, 39) == 0);
      cycle(1'b1);
    end
    reset = 1'b0;
    lv    = 1'b0;
    idle(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
